// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// Module  : fb_scanout
// Brief   : 640x480@60 VGA scan-out of a 160x120 {R,G,B} framebuffer, 4x4 upscale
// Revision: 1.0
// ============================================================================
module fb_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int FB_WIDTH    = 160,
    parameter int SCALE_SHIFT = 2,
    parameter int COLOR_BITS  = 3,
    parameter int ADDR_BITS   = 15
) (
    input  logic                  Clck,
    input  logic                  Reset,
    output logic [ADDR_BITS-1:0]  fb_rd_addr,
    input  logic [COLOR_BITS-1:0] fb_rd_data,
    output logic                  frame_start,
    output logic                  VGA_CLK,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic                  VGA_BLANK_N,
    output logic                  VGA_SYNC_N,
    output logic [9:0]            VGA_R,
    output logic [9:0]            VGA_G,
    output logic [9:0]            VGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] c_h_last   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] c_v_last   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] c_h_act    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] c_v_act    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] c_hs_first = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] c_hs_last  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] c_vs_first = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] c_vs_last  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic                  r_ph;
    logic [HW-1:0]         r_h_cnt;
    logic [VW-1:0]         r_v_cnt;
    logic [ADDR_BITS-1:0]  r_addr;
    logic                  r_hs1;
    logic                  r_vs1;
    logic                  r_act1;
    logic                  r_hs;
    logic                  r_vs;
    logic                  r_blank_n;
    logic [COLOR_BITS-1:0] r_rgb;
    logic                  r_frame_start;

    logic                  w_active;
    logic                  w_hs_raw;
    logic                  w_vs_raw;
    logic [HW-1:0]         w_x;
    logic [VW-1:0]         w_y;
    logic [ADDR_BITS-1:0]  w_y_ext;
    logic [ADDR_BITS-1:0]  w_addr;

    assign w_active = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign w_hs_raw = !((r_h_cnt >= c_hs_first) && (r_h_cnt <= c_hs_last));
    assign w_vs_raw = !((r_v_cnt >= c_vs_first) && (r_v_cnt <= c_vs_last));
    assign w_x      = r_h_cnt >> SCALE_SHIFT;
    assign w_y      = r_v_cnt >> SCALE_SHIFT;
    assign w_y_ext  = ADDR_BITS'(w_y);

    generate
        if (FB_WIDTH == 160) begin : g_addr_shift
            // 160 = 128 + 32, so the row offset is two shifted copies of y
            assign w_addr = (w_y_ext << 7) + (w_y_ext << 5) + ADDR_BITS'(w_x);
        end else begin : g_addr_mul
            localparam logic [ADDR_BITS-1:0] c_fb_width = ADDR_BITS'(FB_WIDTH);
            assign w_addr = (w_y_ext * c_fb_width) + ADDR_BITS'(w_x);
        end
    endgenerate

    always_ff @(posedge Clck) begin
        if (Reset) begin
            r_ph          <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_addr        <= '0;
            r_hs1         <= 1'b1;
            r_vs1         <= 1'b1;
            r_act1        <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank_n     <= 1'b0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_ph          <= ~r_ph;
            // Raised for exactly the Clck cycle in which the (0,0) tick is taken
            r_frame_start <= ~r_ph && (r_h_cnt == '0) && (r_v_cnt == '0);
            if (r_ph) begin
                if (r_h_cnt == c_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end

                if (w_active) begin
                    r_addr <= w_addr;
                end
                r_hs1  <= w_hs_raw;
                r_vs1  <= w_vs_raw;
                r_act1 <= w_active;

                r_hs      <= r_hs1;
                r_vs      <= r_vs1;
                r_blank_n <= r_act1;
                r_rgb     <= r_act1 ? fb_rd_data : '0;
            end
        end
    end

    assign fb_rd_addr  = r_addr;
    assign frame_start = r_frame_start;
    assign VGA_CLK     = r_ph;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = {10{r_rgb[2]}};
    assign VGA_G       = {10{r_rgb[1]}};
    assign VGA_B       = {10{r_rgb[0]}};

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module  : tb_fb_scanout
// Brief   : Scoreboard bench for fb_scanout; expected pins derived from elapsed time
// Revision: 1.0
// ============================================================================
module tb_fb_scanout;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 16,  VF = 2,  VS = 2,  VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int MAX_FAILS = 30;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data = 3'b000;
    logic        frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
    logic [9:0]  vga_r, vga_g, vga_b;

    logic [2:0]  mem [0:32767];

    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;

    always #10 clk = ~clk;

    fb_scanout #(
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB)
    ) dut (
        .Clck        (clk),
        .Reset       (rst),
        .fb_rd_addr  (rd_addr),
        .fb_rd_data  (rd_data),
        .frame_start (frame_start),
        .VGA_CLK     (vga_clk),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .VGA_BLANK_N (vga_blank_n),
        .VGA_SYNC_N  (vga_sync_n),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b)
    );

    // Synchronous-read RAM: data follows the address one Clck later
    always @(posedge clk) rd_data <= mem[rd_addr];

    function automatic logic [14:0] pix(input int h, input int v);
        return 15'((v / 4) * 160 + h / 4);
    endfunction

    // Expected {clk, frame_start, hs, vs, blank_n, sync_n} after t edges since reset
    function automatic logic [5:0] exp_timing(input int t);
        int n, p, h, v;
        logic vc, fs, hs, vs, bl;
        n  = t / 2;
        vc = (t % 2) == 1;
        fs = vc && ((n % FRAME) == 0);
        hs = 1'b1; vs = 1'b1; bl = 1'b0;
        if (n >= 2) begin
            p  = (n - 2) % FRAME;
            h  = p % HT;
            v  = p / HT;
            hs = !(h >= HA + HF && h < HA + HF + HS);
            vs = !(v >= VA + VF && v < VA + VF + VS);
            bl = (h < HA) && (v < VA);
        end
        return {vc, fs, hs, vs, bl, 1'b0};
    endfunction

    function automatic logic [29:0] exp_rgb(input int t);
        int n, p, h, v;
        logic [2:0] c;
        n = t / 2;
        c = 3'b000;
        if (n >= 2) begin
            p = (n - 2) % FRAME;
            h = p % HT;
            v = p / HT;
            if (h < HA && v < VA) c = mem[pix(h, v)];
        end
        return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
    endfunction

    // Address is the one of the most recent visible pixel already scanned
    function automatic logic [14:0] exp_addr(input int t);
        int n, q, h, v;
        n = t / 2;
        if (n < 1) return 15'd0;
        q = (n - 1) % FRAME;
        h = q % HT;
        v = q / HT;
        if (v >= VA) begin
            h = HA - 1;
            v = VA - 1;
        end else if (h >= HA) begin
            h = HA - 1;
        end
        return pix(h, v);
    endfunction

    typedef struct {
        int          t;
        logic [5:0]  timing;
        logic [29:0] rgb;
        logic [14:0] addr;
    } exp_t;

    exp_t exp_q [$];
    int   t_now = 0;
    bit   armed = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            t_now = 0;
            armed = 1'b1;
        end else if (armed) begin
            t_now++;
        end
        if (armed) begin
            e.t      = t_now;
            e.timing = exp_timing(t_now);
            e.rgb    = exp_rgb(t_now);
            e.addr   = exp_addr(t_now);
            exp_q.push_back(e);
        end
    end

    task automatic check(input string name, input int t, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            fails++;
            $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("timing", e.t, 64'({vga_clk, frame_start, vga_hs, vga_vs, vga_blank_n, vga_sync_n}), 64'(e.timing));
            check("rgb",    e.t, 64'({vga_r, vga_g, vga_b}), 64'(e.rgb));
            check("addr",   e.t, 64'(rd_addr), 64'(e.addr));
            if (fails >= MAX_FAILS) begin
                $display("%0d/%0d checks passed", passes, checks);
                $finish;
            end
        end
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME + 1500) @(negedge clk);
        repeat ($urandom_range(3200, 9600)) @(negedge clk);
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME + 1000) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
